// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the two byte requesters, the arbiter and the UART transmitter.
interface uart_tx_arb_if;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [1:0] owner;
    logic       timeout_evt;

    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, tx_ready,
        output a_ready, b_ready, tx_valid, tx_data, owner, timeout_evt
    );

    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, tx_ready,
        input  a_ready, b_ready, tx_valid, tx_data, owner, timeout_evt
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Two-requester packet-lock arbiter feeding one UART transmitter through a single
// output register; the lock is held per packet and dropped on last byte or idle timeout.
module uart_tx_arb #(
    parameter int CLK_HZ     = 6000000,
    parameter int TIMEOUT_US = 1000
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_arb_if.slave  bus
);
    localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int CW          = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_owner, w_owner_nxt;
    logic          r_rr_b,  w_rr_b_nxt;   // 1: B released last, so A wins the next contention
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_evt,   w_evt_nxt;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;

    logic       w_slot_free;
    logic       w_a_ready, w_b_ready;
    logic       w_acc_a, w_acc_b, w_acc;
    logic [7:0] w_acc_data;
    logic       w_acc_last;
    logic       w_own_valid;

    assign w_slot_free = !r_tx_valid || bus.tx_ready;
    assign w_a_ready   = (r_owner == OWN_A) && w_slot_free;
    assign w_b_ready   = (r_owner == OWN_B) && w_slot_free;
    assign w_acc_a     = bus.a_valid && w_a_ready;
    assign w_acc_b     = bus.b_valid && w_b_ready;
    assign w_acc       = w_acc_a || w_acc_b;
    assign w_acc_data  = w_acc_a ? bus.a_data : bus.b_data;
    assign w_acc_last  = w_acc_a ? bus.a_last : bus.b_last;
    assign w_own_valid = (r_owner == OWN_A) ? bus.a_valid :
                         (r_owner == OWN_B) ? bus.b_valid : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_rr_b  <= 1'b1;
            r_cnt   <= '0;
            r_evt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr_b  <= w_rr_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_evt   <= w_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_b_nxt  = r_rr_b;
        w_cnt_nxt   = r_cnt;
        w_evt_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.a_valid && (!bus.b_valid || r_rr_b)) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = OWN_A;
                end else if (bus.b_valid) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = OWN_B;
                end
            end
            ST_LOCKED: begin
                if (w_acc) begin
                    w_cnt_nxt = '0;
                    if (w_acc_last) begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = OWN_NONE;
                        w_rr_b_nxt  = (r_owner == OWN_B);
                    end
                end else if (!w_own_valid) begin
                    // Only an absent owner ages the lock; a stalled transmitter does not.
                    if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = OWN_NONE;
                        w_rr_b_nxt  = (r_owner == OWN_B);
                        w_cnt_nxt   = '0;
                        w_evt_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (w_acc) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_acc_data;
        end else if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign bus.a_ready     = w_a_ready;
    assign bus.b_ready     = w_b_ready;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.tx_data     = r_tx_data;
    assign bus.owner       = r_owner;
    assign bus.timeout_evt = r_evt;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized and directed check of uart_tx_arb against a cycle-level rule model
// plus an in-order byte scoreboard.
module tb_uart_tx_arb;
    localparam int CLK_HZ     = 1000000;
    localparam int TIMEOUT_US = 12;
    localparam int T          = CLK_HZ / 1000000 * TIMEOUT_US;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arb_if bus ();

    uart_tx_arb #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model state: owner 0 none / 1 A / 2 B, rr = owner that released last.
    int   m_owner = 0, m_rr = 2, m_cnt = 0, m_txv = 0, m_txd = 0, m_evt = 0;
    int   n_owner = 0, n_rr = 2, n_cnt = 0, n_txv = 0, n_txd = 0, n_evt = 0;
    logic [7:0] sb_q[$];

    always @(negedge clk) begin
        int ra, rb, ov, rdy, d, l;
        if (!rst) begin
            sb_q.delete();
        end else begin
            ra = (m_owner == 1) && (!m_txv || bus.tx_ready);
            rb = (m_owner == 2) && (!m_txv || bus.tx_ready);
            chk("owner", bus.owner, m_owner);
            chk("a_ready", bus.a_ready, ra);
            chk("b_ready", bus.b_ready, rb);
            chk("tx_valid", bus.tx_valid, m_txv);
            if (m_txv != 0) chk("tx_data", bus.tx_data, m_txd);
            chk("timeout_evt", bus.timeout_evt, m_evt);
            if (bus.tx_valid && bus.tx_ready) begin
                n_xfer++;
                if (sb_q.size() == 0) chk("tx_unexpected", bus.tx_valid, 0);
                else chk("tx_order", bus.tx_data, sb_q.pop_front());
            end
            n_owner = m_owner; n_rr = m_rr; n_cnt = m_cnt; n_evt = 0;
            n_txd = m_txd;
            n_txv = bus.tx_ready ? 0 : m_txv;
            if (m_owner == 0) begin
                n_cnt = 0;
                if (bus.a_valid && bus.b_valid) n_owner = (m_rr == 1) ? 2 : 1;
                else if (bus.a_valid)           n_owner = 1;
                else if (bus.b_valid)           n_owner = 2;
            end else begin
                ov  = (m_owner == 1) ? bus.a_valid : bus.b_valid;
                rdy = (m_owner == 1) ? ra : rb;
                d   = (m_owner == 1) ? bus.a_data : bus.b_data;
                l   = (m_owner == 1) ? bus.a_last : bus.b_last;
                if (ov && rdy) begin
                    n_txv = 1; n_txd = d; n_cnt = 0;
                    sb_q.push_back(8'(d));
                    if (l) begin n_owner = 0; n_rr = m_owner; end
                end else if (!ov) begin
                    if (m_cnt == T - 1) begin
                        n_owner = 0; n_rr = m_owner; n_cnt = 0; n_evt = 1;
                    end else begin
                        n_cnt = m_cnt + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= 0; m_rr <= 2; m_cnt <= 0; m_txv <= 0; m_txd <= 0; m_evt <= 0;
        end else begin
            m_owner <= n_owner; m_rr <= n_rr; m_cnt <= n_cnt;
            m_txv <= n_txv; m_txd <= n_txd; m_evt <= n_evt;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_evt", bus.timeout_evt, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic set_a(input logic v, input logic [7:0] d, input logic l);
        bus.a_valid = v; bus.a_data = d; bus.a_last = l;
    endtask

    task automatic set_b(input logic v, input logic [7:0] d, input logic l);
        bus.b_valid = v; bus.b_data = d; bus.b_last = l;
    endtask

    initial begin
        int pct[3] = '{10, 50, 90};
        int pa, pb, pr, x0;
        set_a(0, 8'h00, 0);
        set_b(0, 8'h00, 0);
        bus.tx_ready = 1'b0;
        cyc();
        do_reset();
        chk("rst_tx_data", bus.tx_data, 8'h00);

        // Contention: A first, back-to-back bytes, then B.
        bus.tx_ready = 1'b1;
        set_a(1, 8'h41, 0);
        set_b(1, 8'h61, 1);
        cyc(); chk("c1_owner", bus.owner, 1); chk("c1_txv", bus.tx_valid, 0);
        cyc(); chk("c2_txd", bus.tx_data, 8'h41); chk("c2_txv", bus.tx_valid, 1);
        set_a(1, 8'h42, 1);
        cyc(); chk("c3_txd", bus.tx_data, 8'h42); chk("c3_owner", bus.owner, 0);
        set_a(0, 8'h00, 0);
        cyc(); chk("c4_owner", bus.owner, 2); chk("c4_txv", bus.tx_valid, 0);
        cyc(); chk("c5_txd", bus.tx_data, 8'h61); chk("c5_owner", bus.owner, 0);

        // Second contention goes to A; A then goes quiet and times out.
        set_a(1, 8'h10, 0);
        set_b(1, 8'h62, 1);
        cyc(); chk("rr_owner", bus.owner, 1);
        cyc(); chk("to_txd", bus.tx_data, 8'h10);
        set_a(0, 8'h00, 0);
        for (int i = 0; i < T - 1; i++) cyc();
        chk("to_pre_owner", bus.owner, 1); chk("to_pre_evt", bus.timeout_evt, 0);
        cyc(); chk("to_evt", bus.timeout_evt, 1); chk("to_owner", bus.owner, 0);
        cyc(); chk("to_post_evt", bus.timeout_evt, 0); chk("to_b_owner", bus.owner, 2);
        cyc(); chk("to_b_txd", bus.tx_data, 8'h62); chk("to_b_rel", bus.owner, 0);
        set_b(0, 8'h00, 0);

        // Long backpressure with owner valid: no timeout, byte held.
        set_a(1, 8'h33, 0);
        cyc(); chk("bp_owner", bus.owner, 1);
        cyc(); chk("bp_txd", bus.tx_data, 8'h33);
        bus.tx_ready = 1'b0;
        set_a(1, 8'h34, 0);
        for (int i = 0; i < 2 * T; i++) cyc();
        chk("bp_hold_txd", bus.tx_data, 8'h33); chk("bp_hold_txv", bus.tx_valid, 1);
        chk("bp_a_ready", bus.a_ready, 0); chk("bp_hold_owner", bus.owner, 1);
        bus.tx_ready = 1'b1;
        set_a(1, 8'h34, 1);
        cyc(); chk("bp_txd2", bus.tx_data, 8'h34); chk("bp_rel", bus.owner, 0);
        set_a(0, 8'h00, 0);
        cyc(); chk("bp_drain", bus.tx_valid, 0);

        // Single-byte packet under a toggling transmitter.
        set_b(1, 8'h7E, 1);
        cyc(); chk("tg_owner", bus.owner, 2);
        x0 = n_xfer;
        cyc(); chk("tg_txd", bus.tx_data, 8'h7E);
        set_b(0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            bus.tx_ready = logic'(i % 2);
            cyc();
            if (bus.tx_valid) chk("tg_stable", bus.tx_data, 8'h7E);
        end
        chk("tg_count", n_xfer - x0, 1);

        // Reset with a held byte under B.
        bus.tx_ready = 1'b0;
        set_b(1, 8'h55, 0);
        cyc(); chk("rs_owner", bus.owner, 2);
        cyc(); chk("rs_txd", bus.tx_data, 8'h55); chk("rs_txv", bus.tx_valid, 1);
        bus.tx_ready = 1'b1;
        #1; chk("rs_b_ready", bus.b_ready, 1);
        do_reset();
        set_b(0, 8'h00, 0);
        cyc(); chk("rs_post_txv", bus.tx_valid, 0);

        // Randomized traffic in blocks of varying request/ready density.
        for (int blk = 0; blk < 60; blk++) begin
            pa = pct[$urandom_range(2)];
            pb = pct[$urandom_range(2)];
            pr = pct[$urandom_range(2)];
            for (int c = 0; c < 50; c++) begin
                set_a(logic'($urandom_range(99) < pa), 8'($urandom), logic'($urandom_range(3) == 0));
                set_b(logic'($urandom_range(99) < pb), 8'($urandom), logic'($urandom_range(3) == 0));
                bus.tx_ready = logic'($urandom_range(99) < pr);
                if ($urandom_range(599) == 0) do_reset();
                else cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
